// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: one req/ack bus transaction per memory op, lane enables/replication, load extract/extend.
// Latency: non-mem/misaligned 0 extra cycles, aligned >=3 cycles (accept, ACCESS..., FINISH); busy freezes upstream while outstanding.
module mem_access_unit #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_op_valid,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [1:0]           i_size,
    input  logic                 i_ext_signed,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_BITS-1:0] i_wdata,
    output logic                 o_bus_req,
    output logic                 o_bus_we,
    output logic [ADDR_BITS-1:0] o_bus_addr,
    output logic [3:0]           o_bus_be,
    output logic [DATA_BITS-1:0] o_bus_wdata,
    input  logic [DATA_BITS-1:0] i_bus_rdata,
    input  logic                 i_bus_ack,
    output logic [DATA_BITS-1:0] o_mem_out,
    output logic                 o_done,
    output logic                 o_busy,
    output logic                 o_misalign,
    output logic                 o_bus_err
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_FINISH} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_bus_we;
    logic [ADDR_BITS-1:0] r_bus_addr;
    logic [3:0]           r_bus_be;
    logic [DATA_BITS-1:0] r_bus_wdata;
    logic [1:0]           r_size;
    logic                 r_ext_signed;
    logic [1:0]           r_lo;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic [DATA_BITS-1:0] r_mem_out;

    logic                 w_is_mem, w_misaligned;
    logic                 w_accept, w_timeout, w_done, w_busy, w_misalign;
    logic [3:0]           w_be;
    logic [DATA_BITS-1:0] w_wdata, w_load;
    logic [7:0]           w_lane_byte;
    logic [15:0]          w_lane_half;
    logic [CNT_W-1:0]     w_cnt_inc;

    assign w_is_mem     = i_mem_read | i_mem_write;
    assign w_misaligned = (i_size == 2'b01) ? i_addr[0]
                        : ((i_size != 2'b00) && (i_addr[1:0] != 2'b00));
    assign w_cnt_inc    = r_cnt + 1'b1;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        case (i_size)
            2'b00: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the latched size/offset; bus_rdata is only meaningful with ack.
    assign w_lane_byte = i_bus_rdata[{r_lo, 3'b000} +: 8];
    assign w_lane_half = r_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

    always_comb begin
        w_load = i_bus_rdata;
        case (r_size)
            2'b00:   w_load = {{24{r_ext_signed & w_lane_byte[7]}}, w_lane_byte};
            2'b01:   w_load = {{16{r_ext_signed & w_lane_half[15]}}, w_lane_half};
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_op_valid) begin
                    if (!w_is_mem) begin
                        w_done = 1'b1;
                    end else if (w_misaligned) begin
                        w_done     = 1'b1;
                        w_misalign = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_busy      = 1'b1;
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                w_busy = 1'b1;
                if (i_bus_ack) begin
                    w_state_nxt = S_FINISH;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
            r_size       <= '0;
            r_ext_signed <= 1'b0;
            r_lo         <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_mem_out    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_bus_we     <= i_mem_write;
                r_bus_addr   <= {i_addr[ADDR_BITS-1:2], 2'b00};
                r_bus_be     <= w_be;
                r_bus_wdata  <= w_wdata;
                r_size       <= i_size;
                r_ext_signed <= i_ext_signed;
                r_lo         <= i_addr[1:0];
                r_cnt        <= '0;
                r_err        <= 1'b0;
            end
            if (r_state == S_ACCESS) begin
                if (i_bus_ack) begin
                    if (!r_bus_we) begin
                        r_mem_out <= w_load;
                    end
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    // Status outputs are forced low while reset is held, regardless of op_valid.
    assign o_done      = w_done & i_rst_n;
    assign o_busy      = w_busy & i_rst_n;
    assign o_misalign  = w_misalign & i_rst_n;
    assign o_bus_err   = (r_state == S_FINISH) & r_err & i_rst_n;
    assign o_bus_req   = (r_state == S_ACCESS);
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_be    = r_bus_be;
    assign o_bus_wdata = r_bus_wdata;
    assign o_mem_out   = r_mem_out;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, reset/idle corner sequences, random ops vs. a reference model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, ext_signed = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_req, bus_we, done, busy, misalign, bus_err;
    logic [31:0] bus_addr, bus_wdata, mem_out;
    logic [3:0]  bus_be;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.DATA_BITS(32), .ADDR_BITS(32), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid), .i_mem_read(mem_read),
        .i_mem_write(mem_write), .i_size(size), .i_ext_signed(ext_signed), .i_addr(addr),
        .i_wdata(wdata), .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_be(bus_be), .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata),
        .i_bus_ack(bus_ack), .o_mem_out(mem_out), .o_done(done), .o_busy(busy),
        .o_misalign(misalign), .o_bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: lane arithmetic straight from the access-size rules.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r = '0;
        int n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(sz);
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8*n)) - 1);
        logic [31:0] v = (rd >> (8 * (a % 4))) & mask;
        if (sgn && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // One instruction from accept to done; waits<0 means the slave never acks.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                          input int waits, input logic [3:0] e_be, input logic [31:0] e_wd,
                          input logic [31:0] e_mem, input logic e_mis, input logic e_err);
        int cyc;
        int e_lat;
        @(negedge clk);
        op_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz; ext_signed = sgn;
        addr = a; wdata = wd; bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        if (!(rd || wr) || e_mis) begin
            check("imm_done", 32'(done), 32'd1);
            check("imm_busy", 32'(busy), 32'd0);
            check("imm_misalign", 32'(misalign), 32'(e_mis));
            check("imm_req", 32'(bus_req), 32'd0);
        end else begin
            check("acc_done", 32'(done), 32'd0);
            check("acc_busy", 32'(busy), 32'd1);
            e_lat = (waits >= 0 && waits < TMO) ? waits + 2 : TMO + 1;
            @(negedge clk);
            op_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            size = 2'($urandom); ext_signed = 1'($urandom); addr = $urandom; wdata = $urandom;
            cyc = 1;
            while (cyc <= TMO + 2) begin
                #1;
                if (done) break;
                check("req_held", 32'(bus_req), 32'd1);
                check("busy_held", 32'(busy), 32'd1);
                check("bus_we", 32'(bus_we), 32'(wr));
                check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                check("bus_be", 32'(bus_be), 32'(e_be));
                if (wr) check("bus_wdata", bus_wdata, e_wd);
                bus_ack = (cyc - 1 == waits);
                bus_rdata = bus_ack ? rdat : $urandom;
                @(negedge clk);
                bus_ack = 1'b0;
                cyc++;
            end
            check("latency", 32'(cyc), 32'(e_lat));
            check("fin_busy", 32'(busy), 32'd0);
            check("fin_req", 32'(bus_req), 32'd0);
            check("fin_bus_err", 32'(bus_err), 32'(e_err));
            check("fin_misalign", 32'(misalign), 32'd0);
        end
        check("mem_out", mem_out, e_mem);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_req", 32'(bus_req), 32'd0);
    endtask

    typedef struct {
        logic        rd, wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] a, wd, rdat;
        int          waits;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_mem;
        logic        e_mis, e_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] m_mem;
        logic rd, wr, sgn, mis, err;
        logic [1:0] sz;
        logic [31:0] a, wd, rdat;
        int waits;

        // rd wr sz sgn addr wdata rdata waits | be wdata mem_out mis err
        vecs.push_back('{1,0,2'd0,1,32'h1003,32'h0,        32'h80FF_0000, 2,4'b1000,32'h0,        32'hFFFF_FF80,0,0});
        vecs.push_back('{0,1,2'd1,0,32'h2002,32'h1234_ABCD,32'h0,         0,4'b1100,32'hABCD_ABCD,32'hFFFF_FF80,0,0});
        vecs.push_back('{1,0,2'd2,0,32'h0006,32'h0,        32'h0,         0,4'b0000,32'h0,        32'hFFFF_FF80,1,0});
        vecs.push_back('{1,0,2'd1,0,32'h0002,32'h0,        32'h0,        -1,4'b1100,32'h0,        32'hFFFF_FF80,0,1});
        vecs.push_back('{0,0,2'd2,0,32'h0005,32'h0,        32'h0,         0,4'b0000,32'h0,        32'hFFFF_FF80,0,0});
        vecs.push_back('{1,0,2'd2,0,32'h0010,32'h0,        32'hDEAD_BEEF, 1,4'b1111,32'h0,        32'hDEAD_BEEF,0,0});
        vecs.push_back('{1,0,2'd1,0,32'h0022,32'h0,        32'h8001_7FFF, 3,4'b1100,32'h0,        32'h0000_8001,0,0});
        vecs.push_back('{1,0,2'd1,1,32'h0020,32'h0,        32'h1234_8001, 0,4'b0011,32'h0,        32'hFFFF_8001,0,0});
        vecs.push_back('{1,0,2'd0,0,32'h0041,32'h0,        32'h0000_9A00, 0,4'b0010,32'h0,        32'h0000_009A,0,0});
        vecs.push_back('{0,1,2'd0,0,32'h0007,32'h0000_00AB,32'h0,         1,4'b1000,32'hABAB_ABAB,32'h0000_009A,0,0});
        vecs.push_back('{1,0,2'd3,0,32'h0008,32'h0,        32'h0102_0304, 0,4'b1111,32'h0,        32'h0102_0304,0,0});
        vecs.push_back('{1,1,2'd2,0,32'h000C,32'hCAFE_F00D,32'h0,         2,4'b1111,32'hCAFE_F00D,32'h0102_0304,0,0});
        vecs.push_back('{0,1,2'd1,0,32'h0001,32'h0,        32'h0,         0,4'b0000,32'h0,        32'h0102_0304,1,0});
        vecs.push_back('{0,1,2'd2,0,32'h0030,32'h1122_3344,32'h0,        -1,4'b1111,32'h1122_3344,32'h0102_0304,0,1});

        // Reset state, with a non-memory op presented to prove status outputs stay low.
        op_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_mem_out", mem_out, 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].sgn, vecs[i].a, vecs[i].wd,
                   vecs[i].rdat, vecs[i].waits, vecs[i].e_be, vecs[i].e_wd, vecs[i].e_mem,
                   vecs[i].e_mis, vecs[i].e_err);

        // Ack while idle must not disturb anything.
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("idle_ack_mem", mem_out, 32'h0102_0304);
        check("idle_ack_done", 32'(done), 32'd0);
        check("idle_ack_req", 32'(bus_req), 32'd0);

        // Back-to-back non-memory ops complete every cycle.
        @(negedge clk);
        op_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("b2b_done", 32'(done), 32'd1);
            check("b2b_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        op_valid = 1'b0;

        // Reset in the middle of ACCESS.
        @(negedge clk);
        op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2; addr = 32'h40;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_req_before", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_req_dropped", 32'(bus_req), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_mem_out", mem_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0,
               32'hDEAD_BEEF, 0, 0);

        // Randomized ops against the reference model.
        m_mem = 32'hDEAD_BEEF;
        for (int t = 0; t < 60; t++) begin
            rd = 1'($urandom); wr = 1'($urandom); sz = 2'($urandom); sgn = 1'($urandom);
            a = {24'h0, 8'($urandom)}; wd = $urandom; rdat = $urandom;
            waits = $urandom_range(0, TMO + 1);
            if (waits == TMO + 1) waits = -1;
            mis = (rd || wr) && m_misaligned(sz, a);
            err = (rd || wr) && !mis && !(waits >= 0 && waits < TMO);
            if (rd && !wr && !mis && !err) m_mem = m_load(sz, sgn, a, rdat);
            run_op(rd, wr, sz, sgn, a, wd, rdat, waits, m_be(sz, a), m_wdata(sz, wd),
                   m_mem, mis, err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage controller sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns one load/store per instruction into a req/ack transaction on the data-memory bus. It generates byte-lane enables and replicated store data, and extracts and extends load data into `mem_out`. It also produces the `done` pulse that lets MEM/WB capture the instruction, holding the pipeline (via `busy`) while a transaction is outstanding.

## Interface

Parameters:
- `DATA_BITS`, 32, data width; fixed at 32 (4 byte lanes).
- `ADDR_BITS`, 32, byte-address width.
- `TIMEOUT`, 255, maximum cycles waiting for `bus_ack` before abort; 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `op_valid` in 1: instruction present in MEM stage.
- `mem_read` in 1: instruction is a load.
- `mem_write` in 1: instruction is a store; wins if both are set.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `ext_signed` in 1: load extension; 1 sign, 0 zero.
- `addr` in ADDR_BITS: byte address from ALU.
- `wdata` in DATA_BITS: store data (low bytes significant).
- `bus_req` out 1: transaction request, held until ack or abort.
- `bus_we` out 1: 1 write, 0 read.
- `bus_addr` out ADDR_BITS: word-aligned address (`addr` with [1:0]=0).
- `bus_be` out 4: byte enables, little-endian.
- `bus_wdata` out DATA_BITS: lane-replicated store data.
- `bus_rdata` in DATA_BITS: read data, valid with `bus_ack`.
- `bus_ack` in 1: transaction complete.
- `mem_out` out DATA_BITS: extended load result, registered.
- `done` out 1: MEM stage finished this cycle; MEM/WB may capture.
- `busy` out 1: stage holding; upstream must freeze.
- `misalign` out 1: one-cycle flag with `done` for a misaligned access.
- `bus_err` out 1: one-cycle flag with `done` for a timed-out access.

## Operation

- FSM states: IDLE, ACCESS, FINISH.
- IDLE, no `op_valid`: `done`=0, `busy`=0.
- IDLE, `op_valid` with neither read nor write: `done`=1 combinationally, `busy`=0. No state change; `mem_out` is unchanged.
- IDLE, valid memory op:
  - If misaligned (half with `addr[0]`=1; word with `addr[1:0]`≠0): `done`=1 and `misalign`=1 that cycle. No bus activity; stay in IDLE.
  - Otherwise: latch `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `size`, `ext_signed`, `addr[1:0]`. Clear the timeout counter, go to ACCESS. `busy`=1 in that cycle.
- Byte enables and store data:
  - Byte at lane k: `bus_be`=1<<k; `bus_wdata` = `wdata[7:0]` replicated ×4.
  - Half: `addr[1]`=0 → 0011, =1 → 1100; `bus_wdata` = `wdata[15:0]` replicated ×2.
  - Word: `bus_be`=1111; `bus_wdata` = `wdata`.
  - Loads drive the same `bus_be`.
- ACCESS: `bus_req`=1, `busy`=1, bus outputs stable.
  - On `bus_ack`: for a load, register the extracted value into `mem_out`; go to FINISH.
  - Byte k extraction: `bus_rdata[8k+7:8k]`. Half: `addr[1]` selects the upper or lower 16 bits. Extension per the latched `ext_signed`.
  - Stores leave `mem_out` unchanged.
- Timeout: counter increments each ACCESS cycle without ack. When the count reaches `TIMEOUT`, drop `bus_req` and go to FINISH with the error flag set; `mem_out` is unchanged.
- FINISH: `done`=1, `busy`=0. `bus_err`=1 if timed out. Return to IDLE.
- `bus_ack` outside ACCESS is ignored.
- Inputs are sampled only in IDLE; changes during ACCESS/FINISH are ignored.

## Timing

- Reset values, applied immediately on `rst_n` low: state IDLE, `bus_req` 0, `bus_we` 0, `bus_addr` 0, `bus_be` 0, `bus_wdata` 0, `mem_out` 0, timeout counter 0, error flag 0. `done`, `busy`, `misalign` and `bus_err` are 0 while in reset.
- Reset mid-transaction drops `bus_req` asynchronously with no `done`; the bus slave must tolerate an abandoned request.
- Aligned memory op, ack in the first ACCESS cycle: accept cycle N, `bus_req` cycles N+1.., `done` at N+2. A minimum of 3 cycles; each extra wait cycle adds 1.
- `mem_out` is valid in the `done` cycle and holds until the next completed load.
- Non-memory and misaligned ops complete in 0 extra cycles.
- Timeout: `done`/`bus_err` appear `TIMEOUT`+1 cycles after entering ACCESS.
- `done` is a single-cycle pulse per instruction, never asserted while `busy`=1.

## Test plan

- LB at `addr`=0x1003, `ext_signed`=1, `bus_rdata`=0x80FF_0000, ack after 2 wait cycles -> `bus_be`=1000, `bus_addr`=0x1000, `mem_out`=0xFFFF_FF80, `done` 4 cycles after accept.
- SH at `addr`=0x2002, `wdata`=0x1234_ABCD, immediate ack -> `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCD_ABCD, `mem_out` unchanged, `done` at N+2.
- LW at `addr`=0x0006 -> `misalign`=1 and `done`=1 the same cycle, `bus_req` never asserted.
- LHU at `addr`=0x0002 with `TIMEOUT`=4, no ack -> `bus_req` high for exactly 4 cycles, then `done`+`bus_err` pulse, `mem_out` unchanged.
- Non-memory op with `op_valid`=1 -> `done`=1 same cycle, `busy`=0; back-to-back ops complete every cycle.
- Assert `rst_n`=0 mid-ACCESS -> `bus_req` falls without waiting for a clock edge, no `done`; after release, a new LW (`bus_rdata`=0xDEAD_BEEF) completes normally with `mem_out`=0xDEAD_BEEF.
